// File: rtl/xor_multiport_memory.sv
// Multi-port RAM built from one bank per write port. The logical word is the XOR of all banks,
// so every port can write every cycle without a shared write port.
module xor_multiport_memory #(
    parameter int PORTS      = 4,
    parameter int DEPTH      = 512,
    parameter int WIDTH      = 64,
    parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS-1:0]            en,
    input  logic [PORTS-1:0]            wr,
    input  logic [PORTS*LOG2_DEPTH-1:0] addr,
    input  logic [PORTS*WIDTH-1:0]      d,
    output logic [PORTS*WIDTH-1:0]      q,
    output logic [PORTS-1:0]            q_valid,
    output logic                        busy,
    output logic [PORTS-1:0]            collision
);

    localparam logic [LOG2_DEPTH:0]   DEPTH_L = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH-1:0] LAST    = LOG2_DEPTH'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_nxt;
    logic [LOG2_DEPTH-1:0] init_cnt;

    logic [WIDTH-1:0]      mem [PORTS][DEPTH];

    logic [PORTS-1:0]      s0_en, s0_wr;
    logic [LOG2_DEPTH-1:0] s0_addr [PORTS];
    logic [WIDTH-1:0]      s0_d    [PORTS];

    logic [PORTS-1:0]      s1_en, s1_wr;
    logic [LOG2_DEPTH-1:0] s1_addr [PORTS];
    logic [WIDTH-1:0]      s1_d    [PORTS];
    logic [WIDTH-1:0]      s1_bank [PORTS][PORTS];

    logic [WIDTH-1:0]      rd_val     [PORTS][PORTS];
    logic [WIDTH-1:0]      commit_val [PORTS];
    logic [WIDTH-1:0]      rd_xor     [PORTS];
    logic [PORTS-1:0]      wr_ok, lose, commit;

    function automatic logic in_range(input logic [LOG2_DEPTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                init_cnt <= (init_cnt == LAST) ? '0 : init_cnt + LOG2_DEPTH'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == LAST) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    assign busy = (state == INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_en <= '0;
            s0_wr <= '0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                s0_addr[p] <= '0;
                s0_d[p]    <= '0;
            end
        end else begin
            s0_en <= (state == READY) ? en : '0;
            s0_wr <= wr;
            for (int unsigned p = 0; p < PORTS; p++) begin
                s0_addr[p] <= addr[p*LOG2_DEPTH +: LOG2_DEPTH];
                s0_d[p]    <= d[p*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 2: arbitration, per-bank commit values and read results.
    always_comb begin
        wr_ok  = '0;
        lose   = '0;
        commit = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            commit_val[p] = s1_d[p];
            rd_xor[p]     = '0;
            for (int unsigned b = 0; b < PORTS; b++) begin
                rd_xor[p] = rd_xor[p] ^ s1_bank[p][b];
                if (b != p) commit_val[p] = commit_val[p] ^ s1_bank[p][b];
            end
            wr_ok[p] = s1_en[p] & s1_wr[p] & in_range(s1_addr[p]);
        end
        for (int unsigned p = 0; p < PORTS; p++) begin
            for (int unsigned j = 0; j < p; j++)
                if (wr_ok[j] && wr_ok[p] && s1_addr[j] == s1_addr[p]) lose[p] = 1'b1;
            commit[p] = wr_ok[p] & ~lose[p];
        end
    end

    // Stage 1 bank reads, forwarding the commit landing at the same edge they are captured.
    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            for (int unsigned b = 0; b < PORTS; b++) begin
                rd_val[p][b] = in_range(s0_addr[p]) ? mem[b][s0_addr[p]] : '0;
                if (commit[b] && s1_addr[b] == s0_addr[p]) rd_val[p][b] = commit_val[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_en <= '0;
            s1_wr <= '0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                s1_addr[p] <= '0;
                s1_d[p]    <= '0;
                for (int unsigned b = 0; b < PORTS; b++) s1_bank[p][b] <= '0;
            end
        end else begin
            s1_en <= s0_en;
            s1_wr <= s0_wr;
            for (int unsigned p = 0; p < PORTS; p++) begin
                s1_addr[p] <= s0_addr[p];
                s1_d[p]    <= s0_d[p];
                for (int unsigned b = 0; b < PORTS; b++) s1_bank[p][b] <= rd_val[p][b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int unsigned b = 0; b < PORTS; b++) mem[b][init_cnt] <= '0;
        end else begin
            for (int unsigned p = 0; p < PORTS; p++)
                if (commit[p]) mem[p][s1_addr[p]] <= commit_val[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            q_valid   <= '0;
            collision <= '0;
        end else begin
            q_valid   <= s1_en & ~s1_wr;
            collision <= lose;
            for (int unsigned p = 0; p < PORTS; p++)
                if (s1_en[p] && !s1_wr[p])
                    q[p*WIDTH +: WIDTH] <= in_range(s1_addr[p]) ? rd_xor[p] : '0;
        end
    end

endmodule
